// File: rtl/fccc_lock_reset_sequencer.sv
// Reset sequencer for the fabric CCC PLL. It qualifies LOCK, then releases the peripheral reset and then the CPU reset.
// Optional build macro LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter output.
module fccc_lock_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned CPU_DELAY     = 16,
    parameter int unsigned HOLD_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock,
    input  logic       soft_reset_req,
    output logic       periph_resetn,
    output logic       cpu_resetn,
    output logic       ready,
    output logic [2:0] state
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        REL_PERIPH = 3'd2,
        RUN        = 3'd3,
        HOLD       = 3'd4
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] CPU_LAST    = 16'(CPU_DELAY - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    logic [1:0]  lock_sync;
    logic        lock_s;
    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt;

    // NOTE: sequential state uses <= only; a blocking write would let the second
    // synchroniser stage pick up the first stage's new value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], lock};
        end
    end

    assign lock_s = lock_sync[1];

    // NOTE: state_d gets its default before the case so no path can infer a latch.
    // Lock loss is tested before the soft request, so a coincident pair counts as lock loss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s)                 state_d = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_d = REL_PERIPH;
            end
            REL_PERIPH: begin
                if (!lock_s)              state_d = HOLD;
                else if (soft_reset_req)  state_d = HOLD;
                else if (cnt == CPU_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s || soft_reset_req) state_d = HOLD;
            end
            HOLD: begin
                if (cnt == HOLD_LAST) state_d = WAIT_LOCK;
            end
            default: state_d = HOLD;
        endcase
    end

    // The shared counter restarts from zero on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_d != state_q) begin
            cnt <= '0;
        end else if (state_q == STABILIZE || state_q == REL_PERIPH || state_q == HOLD) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_LOCK;
            periph_resetn <= 1'b0;
            cpu_resetn    <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state_q       <= state_d;
            periph_resetn <= (state_d == REL_PERIPH) || (state_d == RUN);
            cpu_resetn    <= (state_d == RUN);
            ready         <= (state_d == RUN);
        end
    end

    assign state = state_q;

`ifdef LOCK_LOSS_CNT_EN
    logic lock_lost;

    assign lock_lost = !lock_s && (state_q == REL_PERIPH || state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= 8'h00;
        end else if (lock_lost && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fccc_lock_reset_sequencer.sv
// Self-checking bench for fccc_lock_reset_sequencer: directed scenarios plus random LOCK/soft traffic.
// The reference model is a phase/deadline model; LOCK_LOSS_CNT_EN enables the counter checks.
module tb_fccc_lock_reset_sequencer;

    localparam int STABLE_CYCLES = 8;
    localparam int CPU_DELAY     = 4;
    localparam int HOLD_CYCLES   = 3;

    localparam int PH_WAIT = 0;
    localparam int PH_STAB = 1;
    localparam int PH_REL  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       soft_reset_req;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic       ready;
    logic [2:0] state;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current phase, the edge index at which a timed phase expires,
    // and the two-sample delay that LOCK sees before it can influence the sequence.
    int     m_phase;
    longint m_n;
    longint m_deadline;
    bit     m_s1;
    bit     m_s2;
    int     m_loss;

    fccc_lock_reset_sequencer #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CPU_DELAY    (CPU_DELAY),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lock          (lock),
        .soft_reset_req(soft_reset_req),
        .periph_resetn (periph_resetn),
        .cpu_resetn    (cpu_resetn),
        .ready         (ready),
        .state         (state)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = PH_WAIT;
        m_n        = 0;
        m_deadline = 0;
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        m_loss     = 0;
    endtask

    task automatic enter(input int phase, input int duration);
        m_phase    = phase;
        m_deadline = m_n + duration;
    endtask

    task automatic model_edge();
        bit ls;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
        m_n++;
        case (m_phase)
            PH_WAIT: if (ls) enter(PH_STAB, STABLE_CYCLES);
            PH_STAB: begin
                if (!ls)                  enter(PH_WAIT, 0);
                else if (m_n == m_deadline) enter(PH_REL, CPU_DELAY);
            end
            PH_REL, PH_RUN: begin
                if (!ls) begin
                    if (m_loss < 255) m_loss++;
                    enter(PH_HOLD, HOLD_CYCLES);
                end else if (soft_reset_req) begin
                    enter(PH_HOLD, HOLD_CYCLES);
                end else if (m_phase == PH_REL && m_n == m_deadline) begin
                    enter(PH_RUN, 0);
                end
            end
            PH_HOLD: if (m_n == m_deadline) enter(PH_WAIT, 0);
            default: model_reset();
        endcase
    endtask

    task automatic compare_all();
        check("periph_resetn", periph_resetn, (m_phase == PH_REL || m_phase == PH_RUN));
        check("cpu_resetn", cpu_resetn, (m_phase == PH_RUN));
        check("ready", ready, (m_phase == PH_RUN));
        check("state", state, m_phase);
`ifdef LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int k = 0;
        while (state !== target && k < budget) begin
            step();
            k++;
        end
        check(tag, state, target);
    endtask

    task automatic pulse_soft();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
    endtask

    initial begin
        int p_rise;
        int c_rise;
        int seg_left;

        rst_n          = 1'b1;
        lock           = 1'b0;
        soft_reset_req = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("por_periph_resetn", periph_resetn, 0);
        check("por_cpu_resetn", cpu_resetn, 0);
        check("por_ready", ready, 0);
        check("por_state", state, 0);
        step();
        step();

        // 1: release with LOCK already high at e0.
        rst_n = 1'b1;
        lock  = 1'b1;
        p_rise = -1;
        c_rise = -1;
        for (int e = 0; e <= 15; e++) begin
            step();
            if (p_rise < 0 && periph_resetn === 1'b1) p_rise = e;
            if (c_rise < 0 && cpu_resetn === 1'b1) c_rise = e;
        end
        check("s1_periph_rise_edge", p_rise, STABLE_CYCLES + 2);
        check("s1_cpu_rise_edge", c_rise, STABLE_CYCLES + 2 + CPU_DELAY);
        check("s1_ready", ready, 1);
        check("s1_state", state, 3);

        // 2: LOCK dropout during STABILIZE restarts qualification.
        do_reset();
        lock = 1'b1;
        repeat (6) step();
        check("s2_in_stabilize", state, 1);
        lock = 1'b0;
        repeat (3) step();
        check("s2_back_to_wait", state, 0);
        lock = 1'b1;
        p_rise = -1;
        for (int e = 0; e <= 15; e++) begin
            step();
            if (p_rise < 0 && periph_resetn === 1'b1) p_rise = e;
        end
        check("s2_periph_rise_edge", p_rise, STABLE_CYCLES + 2);
        check("s2_ready", ready, 1);

        // 3: lock loss in RUN; resets drop exactly two edges later, HOLD lasts three cycles.
        lock = 1'b0;
        step();
        check("s3_e0_periph", periph_resetn, 1);
        step();
        check("s3_e1_cpu", cpu_resetn, 1);
        step();
        check("s3_e2_periph", periph_resetn, 0);
        check("s3_e2_cpu", cpu_resetn, 0);
        check("s3_e2_state", state, 4);
        step();
        step();
        check("s3_e4_state", state, 4);
        step();
        check("s3_e5_state", state, 0);
`ifdef LOCK_LOSS_CNT_EN
        check("s3_loss_cnt", lock_loss_cnt, 1);
`endif

        // 4: soft request honoured in RUN, ignored in STABILIZE.
        lock = 1'b1;
        wait_state(3, 40, "s4_reach_run");
        pulse_soft();
        check("s4_soft_state", state, 4);
        check("s4_soft_periph", periph_resetn, 0);
        wait_state(3, 40, "s4_reseq_run");
        pulse_soft();
        wait_state(1, 20, "s4_reach_stab");
        step();
        pulse_soft();
        check("s4_soft_ignored", state, 1);
        wait_state(3, 40, "s4_final_run");
`ifdef LOCK_LOSS_CNT_EN
        check("s4_loss_cnt", lock_loss_cnt, 1);
`endif

        // 5: asynchronous reset in the middle of REL_PERIPH.
        pulse_soft();
        wait_state(2, 40, "s5_reach_rel");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s5_periph", periph_resetn, 0);
        check("s5_cpu", cpu_resetn, 0);
        check("s5_ready", ready, 0);
        check("s5_state", state, 0);
`ifdef LOCK_LOSS_CNT_EN
        check("s5_loss_cnt", lock_loss_cnt, 0);
`endif
        step();
        rst_n = 1'b1;

        // Random LOCK segments, soft pulses and occasional async resets.
        seg_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (seg_left == 0) begin
                lock     = ~lock;
                seg_left = lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            end
            seg_left--;
            soft_reset_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                soft_reset_req = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end
        soft_reset_req = 1'b0;

        // 6: repeated lock losses in REL_PERIPH drive the counter to saturation.
        for (int i = 0; i < 300; i++) begin
            lock = 1'b1;
            wait_state(2, 40, "s6_reach_rel");
            lock = 1'b0;
            repeat (3) step();
        end
        check("s6_state_hold", state, 4);
`ifdef LOCK_LOSS_CNT_EN
        check("s6_loss_cnt_sat", lock_loss_cnt, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
